alu_server: RTL and testbench
=============================

Name: alu_server

Overview:
- Shared fixed-point arithmetic responder for the PID controllers. It serves the key-tagged request/response ALU interface that each PID drives: op, key, A, B in; key, O out.
- Accepts requests from nclients clients.
- Arbitrates round-robin and issues at most one operation per cycle into a single pipelined datapath.
- Returns each result tagged with the request key on that client's response slot.

Parameters:
- nclients, 2, number of client slots; slot i occupies bits [i*w +: w] of every flat bus.
- data_w, 32, operand and result width, signed two's complement.
- key_w, 7, request tag width.
- op_w, 7, opcode width.
- frac, 16, fractional bits for MUL (Q(data_w-frac).frac).
- mul_stages, 2, internal multiplier pipeline registers, minimum 1.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- en, in, 1, grant enable. When low, no new issues are made; in-flight operations still complete.
- op_i, in, nclients*op_w, per-client opcode. 0 means idle.
- key_i, in, nclients*key_w, per-client request tag. Must be nonzero.
- A_i, in, nclients*data_w, per-client operand A.
- B_i, in, nclients*data_w, per-client operand B.
- key_o, out, nclients*key_w, per-client tag of the last completed request.
- O_o, out, nclients*data_w, per-client result of the last completed request.

Behaviour:
- Reset, and the values they hold after it:
  - key_o = 0, O_o = 0.
  - All busy bits cleared.
  - Pipeline valid bits cleared, so every in-flight operation is discarded, with no response.
  - Round-robin pointer = 0.
- Pending condition for client i: op_i != 0, key_i != key_o[i], busy[i] = 0.
- Client handshake:
  - The client holds op/key/A/B stable until key_o[i] == key_i.
  - A new request uses a new key.
  - Keys must be nonzero, because key_o = 0 after reset.
- Arbitration, each cycle with en = 1:
  - Grant the first pending client searching from the pointer upward, wrapping modulo nclients.
  - On grant, set busy[i] and set pointer = (granted + 1) mod nclients.
  - No pending client: the pointer is unchanged.
- Issue:
  - Op, A, B, key and client index are registered into stage 0 on the grant edge.
  - Later input changes do not affect an issued request.
- Latency:
  - Request granted in cycle t; key_o[i] and O_o[i] update together on the edge ending cycle t+mul_stages+1, visible from cycle t+L with L = mul_stages+2 (default 4).
  - All ops use latency L, so results retire in issue order.
  - Throughput is one issue per cycle.
- Retire: write key_o[i] and O_o[i], and clear busy[i] on the same edge.
  - The same client can be re-granted in the next cycle if its key has changed.
- Simultaneous retire and grant for the same client: the retire clears busy. The grant decision that cycle still sees busy = 1, so no grant.
- Operations, with signed saturation to [-2^(data_w-1), 2^(data_w-1)-1]:
  - op 1 ADD: A+B, computed at data_w+1 bits, then saturated.
  - op 2 SUB: A-B, same widening and saturation.
  - op 3 MUL: full 2*data_w signed product, arithmetic shift right by frac (truncation toward -inf), then saturated.
  - Any other nonzero op: result 0, still acknowledged with the key.
- Client outputs only change on retire; otherwise they hold their value.
- en = 0: the pointer holds and no busy bit is set.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_NOP = 0, OP_ADD = 1, OP_SUB = 2, OP_MUL = 3.
  - Default widths: key_w, op_w, data_w.
  - Saturation helper function.
- One sub-module, alu_pipe:
  - The issue-to-retire datapath.
  - Carries valid, client index and key down the pipeline.
  - Contains the multiplier stages and the saturation logic.
- alu_server holds:
  - the pending logic,
  - the round-robin arbiter,
  - the busy bits,
  - the output registers.

Test Plan:
- ADD: reset, then client0 op = 1, key = 5, A = 3, B = 4, granted cycle t -> key_o[0] = 5, O_o[0] = 7 at t+4. The held request is not re-issued (no second retire).
- Saturation: client1 ADD with A = 0x7FFFFFFF, B = 1 -> O_o[1] = 0x7FFFFFFF. SUB with A = 0x80000000, B = 1 -> O_o[1] = 0x80000000.
- MUL Q16.16: A = 0x00018000, B = 0x00020000 -> 0x00030000. A = 0xFFFF8000 (-0.5), B = 0x00030000 -> 0xFFFE8000 (-1.5).
- Contention:
  - Both clients request in the same cycle right after reset: client0 is granted at t, client1 at t+1; results arrive at t+4 and t+5.
  - Repeat the case immediately: client0 is granted first again, because the pointer = 0 after the client1 grant.
- Back-to-back:
  - Client0 changes key 5 -> 6 with a new ADD in the cycle key_o[0] becomes 5 -> granted that cycle, result at +4.
  - en = 0 for 3 cycles with a pending request -> no grant until en rises.
- Reset mid-flight and unknown op:
  - Assert rst 2 cycles after a grant -> no response; key_o = 0 afterwards.
  - After reset, op = 9, key = 2 -> key_o = 2, O_o = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and helpers for the fixed-point ALU server.
package alu_pkg;

    localparam int unsigned KEY_W  = 7;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned DATA_W = 32;

    // Width the saturation check works at; covers 2*data_w for data_w up to 64.
    localparam int unsigned SAT_W = 128;

    localparam int unsigned OP_NOP = 0;
    localparam int unsigned OP_ADD = 1;
    localparam int unsigned OP_SUB = 2;
    localparam int unsigned OP_MUL = 3;

    typedef enum logic [1:0] {
        SatNone,
        SatHigh,
        SatLow
    } sat_e;

    // Classify a wide signed value against the signed range of a w-bit result.
    function automatic sat_e sat_check(input logic signed [SAT_W-1:0] v, input int unsigned w);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        min_v = -max_v - SAT_W'(1);
        if (v > max_v) begin
            return SatHigh;
        end
        if (v < min_v) begin
            return SatLow;
        end
        return SatNone;
    endfunction

endpackage

// File: rtl/alu_server_if.sv
// Flat multi-client request/response bus between the PID clients and the ALU server.
interface alu_server_if
    import alu_pkg::*;
#(
    parameter int unsigned nclients = 2,
    parameter int unsigned data_w   = DATA_W,
    parameter int unsigned key_w    = KEY_W,
    parameter int unsigned op_w     = OP_W
);

    logic                         en;
    logic [nclients*op_w-1:0]     op_i;
    logic [nclients*key_w-1:0]    key_i;
    logic [nclients*data_w-1:0]   A_i;
    logic [nclients*data_w-1:0]   B_i;
    logic [nclients*key_w-1:0]    key_o;
    logic [nclients*data_w-1:0]   O_o;

    modport master (
        output en, op_i, key_i, A_i, B_i,
        input  key_o, O_o
    );

    modport slave (
        input  en, op_i, key_i, A_i, B_i,
        output key_o, O_o
    );

endinterface

// File: rtl/alu_pipe.sv
// Issue-to-retire datapath: stage-0 capture, mul_stages compute stages, output saturation.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned data_w     = DATA_W,
    parameter int unsigned key_w      = KEY_W,
    parameter int unsigned op_w       = OP_W,
    parameter int unsigned idx_w      = 1,
    parameter int unsigned frac       = 16,
    parameter int unsigned mul_stages = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [idx_w-1:0]  i_idx,
    input  logic [key_w-1:0]  i_key,
    input  logic [op_w-1:0]   i_op,
    input  logic [data_w-1:0] i_a,
    input  logic [data_w-1:0] i_b,
    output logic              o_vld,
    output logic [idx_w-1:0]  o_idx,
    output logic [key_w-1:0]  o_key,
    output logic [data_w-1:0] o_res
);

    localparam int unsigned RawW = 2 * data_w;

    logic              r_s0_vld;
    logic [idx_w-1:0]  r_s0_idx;
    logic [key_w-1:0]  r_s0_key;
    logic [op_w-1:0]   r_s0_op;
    logic [data_w-1:0] r_s0_a;
    logic [data_w-1:0] r_s0_b;

    logic signed [data_w:0]   w_a_ext;
    logic signed [data_w:0]   w_b_ext;
    logic signed [RawW-1:0]   w_a_wide;
    logic signed [RawW-1:0]   w_b_wide;
    logic signed [RawW-1:0]   w_prod;
    logic signed [RawW-1:0]   w_raw;

    logic                   r_st_vld [mul_stages];
    logic [idx_w-1:0]       r_st_idx [mul_stages];
    logic [key_w-1:0]       r_st_key [mul_stages];
    logic signed [RawW-1:0] r_st_raw [mul_stages];

    sat_e w_sat;

    // Capture the granted request so later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_vld <= 1'b0;
            r_s0_idx <= '0;
            r_s0_key <= '0;
            r_s0_op  <= '0;
            r_s0_a   <= '0;
            r_s0_b   <= '0;
        end else begin
            r_s0_vld <= i_vld;
            if (i_vld) begin
                r_s0_idx <= i_idx;
                r_s0_key <= i_key;
                r_s0_op  <= i_op;
                r_s0_a   <= i_a;
                r_s0_b   <= i_b;
            end
        end
    end

    // Widened add/sub and full-width product, reduced to one raw value per op
    always_comb begin
        w_a_ext  = {r_s0_a[data_w-1], r_s0_a};
        w_b_ext  = {r_s0_b[data_w-1], r_s0_b};
        w_a_wide = RawW'($signed(r_s0_a));
        w_b_wide = RawW'($signed(r_s0_b));
        w_prod   = w_a_wide * w_b_wide;
        w_raw    = '0;
        if (r_s0_op == op_w'(OP_ADD)) begin
            w_raw = RawW'(w_a_ext + w_b_ext);
        end else if (r_s0_op == op_w'(OP_SUB)) begin
            w_raw = RawW'(w_a_ext - w_b_ext);
        end else if (r_s0_op == op_w'(OP_MUL)) begin
            // Arithmetic shift truncates toward -inf
            w_raw = w_prod >>> frac;
        end
    end

    // Compute stages; every op travels the same depth so results retire in issue order
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < mul_stages; s++) begin
                r_st_vld[s] <= 1'b0;
                r_st_idx[s] <= '0;
                r_st_key[s] <= '0;
                r_st_raw[s] <= '0;
            end
        end else begin
            r_st_vld[0] <= r_s0_vld;
            r_st_idx[0] <= r_s0_idx;
            r_st_key[0] <= r_s0_key;
            r_st_raw[0] <= w_raw;
            for (int s = 1; s < mul_stages; s++) begin
                r_st_vld[s] <= r_st_vld[s-1];
                r_st_idx[s] <= r_st_idx[s-1];
                r_st_key[s] <= r_st_key[s-1];
                r_st_raw[s] <= r_st_raw[s-1];
            end
        end
    end

    // Clamp the last-stage raw value into the signed data_w range
    always_comb begin
        w_sat = sat_check(SAT_W'(r_st_raw[mul_stages-1]), data_w);
        o_res = r_st_raw[mul_stages-1][data_w-1:0];
        case (w_sat)
            SatHigh: o_res = {1'b0, {(data_w-1){1'b1}}};
            SatLow:  o_res = {1'b1, {(data_w-1){1'b0}}};
            default: o_res = r_st_raw[mul_stages-1][data_w-1:0];
        endcase
    end

    assign o_vld = r_st_vld[mul_stages-1];
    assign o_idx = r_st_idx[mul_stages-1];
    assign o_key = r_st_key[mul_stages-1];

endmodule

// File: rtl/alu_server.sv
// Shared ALU responder: pending detection, round-robin arbiter, busy bits, response registers.
module alu_server
    import alu_pkg::*;
#(
    parameter int unsigned nclients   = 2,
    parameter int unsigned data_w     = DATA_W,
    parameter int unsigned key_w      = KEY_W,
    parameter int unsigned op_w       = OP_W,
    parameter int unsigned frac       = 16,
    parameter int unsigned mul_stages = 2
) (
    input logic         clk,
    input logic         rst,
    alu_server_if.slave bus
);

    localparam int unsigned idx_w = (nclients > 1) ? $clog2(nclients) : 1;

    logic [nclients-1:0]        w_pend;
    logic [nclients-1:0]        r_busy;
    logic [idx_w-1:0]           r_ptr;
    logic                       w_gnt;
    logic [idx_w-1:0]           w_gnt_idx;
    logic [nclients*key_w-1:0]  r_key_o;
    logic [nclients*data_w-1:0] r_o_o;

    logic                       w_ret_vld;
    logic [idx_w-1:0]           w_ret_idx;
    logic [key_w-1:0]           w_ret_key;
    logic [data_w-1:0]          w_ret_res;

    // A client is pending when it asks for work under a key not yet answered
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < nclients; i++) begin
            w_pend[i] = (bus.op_i[i*op_w +: op_w] != '0)
                     && (bus.key_i[i*key_w +: key_w] != r_key_o[i*key_w +: key_w])
                     && !r_busy[i];
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo nclients
    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < nclients; k++) begin
            int cand;
            cand = int'(r_ptr) + k;
            if (cand >= int'(nclients)) begin
                cand = cand - int'(nclients);
            end
            if (bus.en && !w_gnt && w_pend[idx_w'(cand)]) begin
                w_gnt     = 1'b1;
                w_gnt_idx = idx_w'(cand);
            end
        end
    end

    alu_pipe #(
        .data_w     (data_w),
        .key_w      (key_w),
        .op_w       (op_w),
        .idx_w      (idx_w),
        .frac       (frac),
        .mul_stages (mul_stages)
    ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_gnt),
        .i_idx (w_gnt_idx),
        .i_key (bus.key_i[w_gnt_idx*key_w +: key_w]),
        .i_op  (bus.op_i[w_gnt_idx*op_w +: op_w]),
        .i_a   (bus.A_i[w_gnt_idx*data_w +: data_w]),
        .i_b   (bus.B_i[w_gnt_idx*data_w +: data_w]),
        .o_vld (w_ret_vld),
        .o_idx (w_ret_idx),
        .o_key (w_ret_key),
        .o_res (w_ret_res)
    );

    // Retire writes the response slot and frees the client; grant marks it busy.
    // A grant never targets a client retiring this cycle since its busy bit is still set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_ptr   <= '0;
            r_key_o <= '0;
            r_o_o   <= '0;
        end else begin
            if (w_ret_vld) begin
                r_busy[w_ret_idx]                    <= 1'b0;
                r_key_o[w_ret_idx*key_w +: key_w]    <= w_ret_key;
                r_o_o[w_ret_idx*data_w +: data_w]    <= w_ret_res;
            end
            if (w_gnt) begin
                r_busy[w_gnt_idx] <= 1'b1;
                r_ptr <= (int'(w_gnt_idx) + 1 >= int'(nclients)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign bus.key_o = r_key_o;
    assign bus.O_o   = r_o_o;

endmodule

// File: tb/tb_alu_server.sv
// Self-checking bench for alu_server: directed latency/boundary steps, then random traffic.
module tb_alu_server;

    localparam int unsigned NC = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 7;
    localparam int unsigned OW = 7;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    alu_server_if #(.nclients(NC), .data_w(DW), .key_w(KW), .op_w(OW)) bus ();

    alu_server #(
        .nclients   (NC),
        .data_w     (DW),
        .key_w      (KW),
        .op_w       (OW),
        .frac       (16),
        .mul_stages (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input int c, input logic [OW-1:0] op, input logic [KW-1:0] key,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.op_i[c*OW +: OW]  = op;
        bus.key_i[c*KW +: KW] = key;
        bus.A_i[c*DW +: DW]   = a;
        bus.B_i[c*DW +: DW]   = b;
    endtask

    function automatic logic [KW-1:0] kout(input int c);
        return bus.key_o[c*KW +: KW];
    endfunction

    function automatic logic [DW-1:0] oout(input int c);
        return bus.O_o[c*DW +: DW];
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    // Reference arithmetic on plain 64-bit integers
    function automatic logic [31:0] ref_alu(input int unsigned op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            1: return sat32(sa + sb);
            2: return sat32(sa - sb);
            3: return sat32((sa * sb) >>> 16);
            default: return 32'h0;
        endcase
    endfunction

    logic [KW-1:0] exp_key  [NC];
    logic [KW-1:0] prev_key [NC];
    logic [DW-1:0] exp_res  [NC];
    int            iss_cyc  [NC];
    bit            outst    [NC];

    initial begin
        int unsigned   rop;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic [KW-1:0] ko;
        int            age;

        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.en   = 1'b1;
        bus.op_i = '0; bus.key_i = '0; bus.A_i = '0; bus.B_i = '0;
        steps(3);
        rst = 1'b0;
        step();
        check("rst_key0", kout(0), 0);
        check("rst_key1", kout(1), 0);
        check("rst_o0", oout(0), 0);
        check("rst_o1", oout(1), 0);

        // ADD with exact latency
        drive(0, 7'd1, 7'd5, 32'd3, 32'd4);
        steps(3);
        check("add_early", kout(0), 0);
        step();
        check("add_key", kout(0), 5);
        check("add_res", oout(0), 7);

        // New key in the very cycle the response appears
        drive(0, 7'd1, 7'd6, 32'd10, -32'sd3);
        steps(3);
        check("b2b_early", kout(0), 5);
        step();
        check("b2b_key", kout(0), 6);
        check("b2b_res", oout(0), 7);
        steps(6);
        check("hold_key", kout(0), 6);
        check("hold_res", oout(0), 7);

        // Saturation on client 1
        drive(1, 7'd1, 7'd1, 32'h7FFF_FFFF, 32'd1);
        steps(4);
        check("sat_add_key", kout(1), 1);
        check("sat_add_res", oout(1), 32'h7FFF_FFFF);
        drive(1, 7'd2, 7'd2, 32'h8000_0000, 32'd1);
        steps(4);
        check("sat_sub_key", kout(1), 2);
        check("sat_sub_res", oout(1), 32'h8000_0000);

        // Q16.16 multiplies
        drive(0, 7'd3, 7'd7, 32'h0001_8000, 32'h0002_0000);
        steps(4);
        check("mul_pos_key", kout(0), 7);
        check("mul_pos_res", oout(0), 32'h0003_0000);
        drive(0, 7'd3, 7'd8, 32'hFFFF_8000, 32'h0003_0000);
        steps(4);
        check("mul_neg_key", kout(0), 8);
        check("mul_neg_res", oout(0), 32'hFFFE_8000);

        // Grant enable held low
        bus.en = 1'b0;
        drive(1, 7'd1, 7'd3, 32'd1, 32'd1);
        steps(6);
        check("en_low_key", kout(1), 2);
        bus.en = 1'b1;
        steps(3);
        check("en_rise_early", kout(1), 2);
        step();
        check("en_rise_key", kout(1), 3);
        check("en_rise_res", oout(1), 2);

        // Contention right after reset, then again immediately
        rst = 1'b1;
        drive(0, 7'd1, 7'd10, 32'd1, 32'd2);
        drive(1, 7'd2, 7'd11, 32'd5, 32'd7);
        step();
        rst = 1'b0;
        steps(3);
        check("cont_early0", kout(0), 0);
        step();
        check("cont_key0", kout(0), 10);
        check("cont_res0", oout(0), 3);
        check("cont_wait1", kout(1), 0);
        step();
        check("cont_key1", kout(1), 11);
        check("cont_res1", oout(1), 32'hFFFF_FFFE);
        drive(0, 7'd1, 7'd12, 32'd100, 32'd1);
        drive(1, 7'd1, 7'd13, 32'd200, 32'd2);
        steps(4);
        check("rep_key0", kout(0), 12);
        check("rep_res0", oout(0), 101);
        check("rep_wait1", kout(1), 11);
        step();
        check("rep_key1", kout(1), 13);
        check("rep_res1", oout(1), 202);

        // Reset two cycles after a grant discards the in-flight op
        drive(0, 7'd1, 7'd20, 32'd1, 32'd1);
        steps(2);
        rst = 1'b1;
        bus.op_i = '0;
        step();
        rst = 1'b0;
        steps(6);
        check("midrst_key0", kout(0), 0);
        check("midrst_o0", oout(0), 0);
        check("midrst_key1", kout(1), 0);

        // Unknown opcode still acknowledged, with a zero result
        drive(0, 7'd9, 7'd2, 32'd5, 32'd6);
        steps(3);
        check("unk_early", kout(0), 0);
        step();
        check("unk_key", kout(0), 2);
        check("unk_res", oout(0), 0);

        // Random traffic against the reference model
        for (int c = 0; c < NC; c++) outst[c] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                ko = kout(c);
                if (outst[c]) begin
                    age = cyc - iss_cyc[c];
                    if (ko == exp_key[c]) begin
                        check("rnd_res", oout(c), exp_res[c]);
                        check("rnd_lat", 64'(age >= 4 && age <= 5), 1);
                        outst[c] = 1'b0;
                    end else begin
                        check("rnd_hold", ko, prev_key[c]);
                        if (age > 8) begin
                            check("rnd_timeout", ko, exp_key[c]);
                            outst[c] = 1'b0;
                        end
                    end
                end else if ($urandom_range(0, 2) != 0) begin
                    case ($urandom_range(0, 4))
                        0: rop = 1;
                        1: rop = 2;
                        2, 3: rop = 3;
                        default: rop = $urandom_range(4, 127);
                    endcase
                    ra = $urandom;
                    rb = $urandom;
                    if ($urandom_range(0, 1) != 0) ra = 32'($urandom_range(0, 262143)) - 32'd131072;
                    if ($urandom_range(0, 1) != 0) rb = 32'($urandom_range(0, 262143)) - 32'd131072;
                    prev_key[c] = ko;
                    exp_key[c]  = KW'((int'(ko) % 127) + 1);
                    exp_res[c]  = ref_alu(rop, ra, rb);
                    iss_cyc[c]  = cyc;
                    outst[c]    = 1'b1;
                    drive(c, OW'(rop), exp_key[c], ra, rb);
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
